// File: rtl/system_0_sysid_checker.sv
// Avalon-MM read master that fetches the sysid and timestamp words
// and compares them against build-time expected values.
module system_0_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1562245726,
  parameter int          READ_LATENCY       = 0,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP
  } state_t;

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  state_t     state;
  state_t     state_nx;
  logic [1:0] cnt;
  logic       auto_pend;
  logic       lat_hit;
  logic       launch;

  assign lat_hit = (cnt == LAT);
  assign launch  = (state == IDLE) && (start || auto_pend);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start || auto_pend) state_nx = RD_ID;
      RD_ID:   if (lat_hit) state_nx = RD_TS;
      RD_TS:   if (lat_hit) state_nx = CMP;
      CMP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Wait counter restarts at every read phase boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 2'd0;
      auto_pend <= AUTO_START;
    end else begin
      auto_pend <= 1'b0;
      if ((state == RD_ID || state == RD_TS) && !lat_hit)
        cnt <= cnt + 2'd1;
      else
        cnt <= 2'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (state == RD_ID && lat_hit) id_value <= sysid_readdata;
      if (state == RD_TS && lat_hit) ts_value <= sysid_readdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done  <= 1'b0;
      valid <= 1'b0;
      id_ok <= 1'b0;
      ts_ok <= 1'b0;
      match <= 1'b0;
    end else begin
      done <= (state == CMP);
      if (launch) begin
        valid <= 1'b0;
        id_ok <= 1'b0;
        ts_ok <= 1'b0;
        match <= 1'b0;
      end else if (state == CMP) begin
        valid <= 1'b1;
        id_ok <= (id_value == EXPECTED_ID);
        ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
        match <= (id_value == EXPECTED_ID) &&
                 (ts_value == EXPECTED_TIMESTAMP);
      end
    end
  end

  assign busy          = (state != IDLE);
  assign sysid_read    = (state == RD_ID) || (state == RD_TS);
  assign sysid_address = (state == RD_TS);

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Bench for system_0_sysid_checker: latency 0 and latency 3 instances,
// each in front of a behavioural sysid slave with programmable delay.
module tb_system_0_sysid_checker;

  localparam logic [31:0] TS0  = 32'h5D1D_FA5E;
  localparam logic [31:0] ID1  = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  addr, rd, busy, done, valid, id_ok, ts_ok, match;
  logic [31:0] rdata [2];
  logic [31:0] idv [2];
  logic [31:0] tsv [2];

  logic [31:0] mem_id [2];
  logic [31:0] mem_ts [2];
  int          dly [2];
  int          run [2];
  int          run_q [2];
  logic [1:0]  prev_rd, prev_addr;

  int errors = 0;
  int checks = 0;
  int bc, di, bd;

  always #5 clk = ~clk;

  system_0_sysid_checker u0 (
    .clock(clk), .reset_n(rst_n), .start(start[0]),
    .sysid_address(addr[0]), .sysid_read(rd[0]),
    .sysid_readdata(rdata[0]), .busy(busy[0]), .done(done[0]),
    .valid(valid[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
    .match(match[0]), .id_value(idv[0]), .ts_value(tsv[0])
  );

  system_0_sysid_checker #(
    .EXPECTED_ID(ID1), .READ_LATENCY(3)
  ) u1 (
    .clock(clk), .reset_n(rst_n), .start(start[1]),
    .sysid_address(addr[1]), .sysid_read(rd[1]),
    .sysid_readdata(rdata[1]), .busy(busy[1]), .done(done[1]),
    .valid(valid[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
    .match(match[1]), .id_value(idv[1]), .ts_value(tsv[1])
  );

  // Slave: a word is only correct on the cycle where its address has
  // been held for exactly dly cycles; otherwise it returns the inverse.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] w;
      run[k] = (prev_rd[k] && prev_addr[k] == addr[k]) ? run_q[k] + 1 : 0;
      w = addr[k] ? mem_ts[k] : mem_id[k];
      rdata[k] = (run[k] == dly[k]) ? w : ~w;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_rd   <= '0;
      prev_addr <= '0;
      run_q[0]  <= 0;
      run_q[1]  <= 0;
    end else begin
      prev_rd   <= rd;
      prev_addr <= addr;
      run_q[0]  <= run[0];
      run_q[1]  <= run[1];
    end
  end

  function automatic int lat(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic logic [31:0] eid(input int k);
    return (k == 1) ? ID1 : 32'd0;
  endfunction

  function automatic logic [31:0] cap(input int k, input logic [31:0] w);
    return (dly[k] == lat(k)) ? w : ~w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic entry(input int k);
    chk($sformatf("entry%0d_busy", k), 32'(busy[k]), 32'd1);
    chk($sformatf("entry%0d_read", k), 32'(rd[k]), 32'd1);
    chk($sformatf("entry%0d_addr", k), 32'(addr[k]), 32'd0);
    chk($sformatf("entry%0d_valid", k), 32'({valid[k], match[k]}), 32'd0);
  endtask

  // Called on the negedge of the first RD_ID cycle; returns on the
  // negedge where done is seen (or after the cycle budget).
  task automatic wait_done(input int k, input int poke);
    int l;
    logic e_rd, e_addr;
    l  = lat(k);
    bc = 0;
    di = -1;
    bd = 0;
    for (int i = 0; i < 60; i++) begin
      if (done[k]) begin
        di = i;
        break;
      end
      if (busy[k]) bc++;
      e_rd   = (i <= 1 + 2 * l);
      e_addr = (i > l) && (i <= 1 + 2 * l);
      if (rd[k] !== e_rd || addr[k] !== e_addr) bd++;
      start[k] = (i == poke);
      @(negedge clk);
    end
    start[k] = 1'b0;
  endtask

  task automatic results(input int k, input string tag);
    logic [31:0] ei, et;
    int n;
    ei = cap(k, mem_id[k]);
    et = cap(k, mem_ts[k]);
    n  = 3 + 2 * lat(k);
    chk({tag, "_done_at"}, 32'(di), 32'(n));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(n));
    chk({tag, "_bus_seq"}, 32'(bd), 32'd0);
    chk({tag, "_valid"}, 32'(valid[k]), 32'd1);
    chk({tag, "_id_value"}, idv[k], ei);
    chk({tag, "_ts_value"}, tsv[k], et);
    chk({tag, "_id_ok"}, 32'(id_ok[k]), 32'(ei == eid(k)));
    chk({tag, "_ts_ok"}, 32'(ts_ok[k]), 32'(et == TS0));
    chk({tag, "_match"}, 32'(match[k]),
        32'((ei == eid(k)) && (et == TS0)));
  endtask

  task automatic run_one(input int k, input string tag);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    entry(k);
    wait_done(k, -1);
    results(k, tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done[k]), 32'd0);
  endtask

  task automatic all_zero(input int k, input string tag);
    chk({tag, "_ctl"}, 32'({busy[k], done[k], valid[k], rd[k], addr[k],
                            id_ok[k], ts_ok[k], match[k]}), 32'd0);
    chk({tag, "_words"}, idv[k] | tsv[k], 32'd0);
  endtask

  initial begin
    mem_id[0] = 32'd0;
    mem_ts[0] = TS0;
    dly[0]    = 0;
    mem_id[1] = ID1;
    mem_ts[1] = TS0;
    dly[1]    = 3;

    repeat (3) @(negedge clk);
    all_zero(0, "rst0");
    all_zero(1, "rst1");

    rst_n = 1'b1;
    @(negedge clk);
    entry(0);
    entry(1);
    wait_done(0, -1);
    results(0, "auto0");
    for (int i = 0; i < 20 && busy[1]; i++) @(negedge clk);
    @(negedge clk);
    chk("auto1_match", 32'({valid[1], match[1]}), 32'd3);
    chk("auto1_ts", tsv[1], TS0);

    mem_ts[0] = 32'h5D1D_FA5F;
    run_one(0, "badts0");

    dly[1] = 2;
    run_one(1, "dly2");

    dly[1]    = 3;
    mem_ts[0] = TS0;
    start[1]  = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    entry(1);
    wait_done(1, 5);
    results(1, "poke");
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    chk("chain_done_pulse", 32'(done[1]), 32'd0);
    entry(1);
    wait_done(1, -1);
    results(1, "chain");
    bd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done[1] || busy[1]) bd++;
    end
    chk("chain_no_extra", 32'(bd), 32'd0);

    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_in_rdts", 32'({rd[1], addr[1]}), 32'd3);
    rst_n = 1'b0;
    #1;
    all_zero(0, "arst0");
    all_zero(1, "arst1");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    entry(1);
    wait_done(1, -1);
    results(1, "rerun1");
    chk("rerun0_match", 32'({valid[0], match[0]}), 32'd3);
    @(negedge clk);

    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 2; k++) begin
        dly[k]    = (k == 1) ? int'($urandom_range(0, 3))
                             : int'($urandom_range(0, 1));
        mem_id[k] = $urandom_range(0, 1) ? eid(k) : $urandom;
        mem_ts[k] = $urandom_range(0, 1) ? TS0 : $urandom;
        run_one(k, $sformatf("rnd%0d_%0d", it, k));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
